pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
Hardware performance monitor for the 5-stage pipelined CPU; consumes pipeline status (hazard stall, jump/branch, flush, writeback-retire) and keeps the cycle, stall, flush and retired-instruction counts in hardware.
Sits beside the CPU top level, downstream of the Hazard Detection, Control and flush logic.
Enforces a programmable run limit by raising halt_o after a fixed number of counted cycles.
Exposes counters through a registered select/read port for debug and bench checking.

Parameters:
CNT_W, 32, width of every counter and of rdata_o
CYCLE_LIMIT, 30, counted cycles after which halt_o asserts; 0 = no limit

Ports:
clk_i  in  1  clock, all logic on posedge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  run enable from CPU top; level-sensitive
stall_i  in  1  hazard detection unit stall request
is_jump_i  in  1  Control jump decode for the instruction in ID
is_branch_i  in  1  Control branch decode for the instruction in ID
flush_i  in  1  IF/ID flush from taken branch/jump
retire_i  in  1  valid instruction in WB (non-bubble)
clear_i  in  1  synchronous counter clear
sel_i  in  3  read select
rdata_o  out  CNT_W  registered read data
halt_o  out  1  run limit reached
state_o  out  2  current FSM state (00 IDLE, 01 RUN, 10 HALTED)

Behaviour:
- Reset: rst_i low at a posedge. All counters, rdata_o and halt_o go to 0; state goes to IDLE. Reset takes priority over everything.
- Priority per edge: reset > clear_i > state transition/counting.
- clear_i=1 in any state: all four counters go to 0, halt_o goes to 0, state goes to IDLE, and no counting happens on that edge.
- FSM transitions:
  - IDLE -> RUN on an edge with start_i=1. That edge is not counted.
  - RUN -> IDLE on an edge with start_i=0 (pause). Counters hold their values; restarting resumes from the held values.
  - RUN -> HALTED on the edge where cycle_cnt becomes CYCLE_LIMIT (CYCLE_LIMIT≠0). halt_o is registered to 1 on that same edge.
  - HALTED: counters frozen, start_i ignored. Leaves only via clear_i or reset.
- Counting applies on every edge where the registered state is RUN and start_i=1. All four counters update independently and simultaneously:
  - cycle_cnt += 1 unconditionally.
  - stall_cnt += 1 iff stall_i & ~is_jump_i & ~is_branch_i. Control-hazard stalls are excluded.
  - flush_cnt += 1 iff flush_i.
  - retire_cnt += 1 iff retire_i.
- Arithmetic: unsigned, CNT_W bits. Every counter saturates at all-ones and never wraps.
- The CYCLE_LIMIT compare uses the post-increment value, so with CYCLE_LIMIT=N exactly N cycles are counted.
- Read port: rdata_o is registered, 1-cycle latency. It is updated every edge, in all states including HALTED.
  - sel_i 0: cycle_cnt
  - sel_i 1: stall_cnt
  - sel_i 2: flush_cnt
  - sel_i 3: retire_cnt
  - sel_i 4: status = {halt_o, state_o} zero-extended
  - sel_i 5..7: 0
- The readback after clear_i on edge k shows 0 from edge k+1.
- state_o is combinationally driven from the state register. halt_o is a register.
- An X on the inputs while in IDLE/HALTED must not disturb the counters.

Decomposition:
- Shared package (cpu_pkg): state encoding constants PM_IDLE/PM_RUN/PM_HALTED; read-select constants PM_SEL_CYCLE/STALL/FLUSH/RETIRE/STATUS.
- One natural sub-module: sat_counter (CNT_W-wide; enable and clear inputs; saturating increment), instantiated four times. The FSM, limit compare and read mux stay in the top.

Test Plan:
- Reset then start: rst_i low 2 cycles, then high with start_i=1 for 30 edges and no events. Expect state RUN then HALTED, halt_o=1 on the 30th counted edge, cycle=30, and the others 0.
- Stall filtering: during RUN, 5 edges of stall_i=1 with jump=branch=0, then 3 edges of stall_i=1 with is_branch_i=1. Expect stall_cnt=5.
- Simultaneous events: one edge with stall_i, flush_i and retire_i all 1. Expect stall, flush and retire each +1 and cycle +1.
- Pause/resume: 10 counted cycles, start_i=0 for 4 edges, then start_i=1 for 5 edges. Expect cycle=15 (IDLE->RUN edge not counted) and state IDLE during the pause.
- Clear mid-run and in HALTED: clear_i with counters at 12 gives all counters 0, state IDLE, and rdata_o=0 one edge later. clear_i in HALTED gives halt_o=0.
- Saturation/readback: CNT_W=4 with CYCLE_LIMIT=0, run 20 cycles. Expect cycle_cnt=15 and no wrap. Sweep sel_i 0..7 and check the values at 1-cycle latency, with status=1 (RUN) and 5..7 reading 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the pipeline performance monitor.
//                Holds the FSM state encoding, the read-select codes and a
//                helper that packs the status word.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // FSM state encoding. The values are visible on state_o, so they are fixed.
    localparam logic [1:0] PM_IDLE    = 2'b00;
    localparam logic [1:0] PM_RUN     = 2'b01;
    localparam logic [1:0] PM_HALTED  = 2'b10;

    // Read-select codes for the debug read port.
    localparam logic [2:0] PM_SEL_CYCLE  = 3'd0;
    localparam logic [2:0] PM_SEL_STALL  = 3'd1;
    localparam logic [2:0] PM_SEL_FLUSH  = 3'd2;
    localparam logic [2:0] PM_SEL_RETIRE = 3'd3;
    localparam logic [2:0] PM_SEL_STATUS = 3'd4;

    // Counter slot indices inside the top-level counter array.
    localparam int PM_CNT_CYCLE  = 0;
    localparam int PM_CNT_STALL  = 1;
    localparam int PM_CNT_FLUSH  = 2;
    localparam int PM_CNT_RETIRE = 3;
    localparam int PM_NUM_CNT    = 4;

    // Status word: {halt, state}.
    function automatic logic [2:0] pm_status(input logic halt, input logic [1:0] state);
        return {halt, state};
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pipe_perf_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_perf_monitor_if
//  Description : Status and read-port bundle between the CPU top level and
//                the performance monitor.
//  Signals     : start_i, stall_i, is_jump_i, is_branch_i, flush_i,
//                retire_i, clear_i, sel_i[2:0]        (CPU -> monitor)
//                rdata_o[CNT_W-1:0], halt_o, state_o  (monitor -> CPU)
//  Modports    : master - CPU / bench side, slave - monitor side
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             stall_i;
    logic             is_jump_i;
    logic             is_branch_i;
    logic             flush_i;
    logic             retire_i;
    logic             clear_i;
    logic [2:0]       sel_i;
    logic [CNT_W-1:0] rdata_o;
    logic             halt_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, stall_i, is_jump_i, is_branch_i, flush_i,
               retire_i, clear_i, sel_i,
        input  rdata_o, halt_o, state_o
    );

    modport slave (
        input  start_i, stall_i, is_jump_i, is_branch_i, flush_i,
               retire_i, clear_i, sel_i,
        output rdata_o, halt_o, state_o
    );

endinterface : pipe_perf_monitor_if
`default_nettype wire

// File: rtl/pipe_perf_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. Holds at
//                all-ones instead of wrapping. o_next exposes the value the
//                register takes on the coming edge (ignoring clear/reset).
//  Ports       : clk_i   - clock
//                rst_i   - synchronous reset, active-low
//                i_clr   - synchronous clear (wins over i_en)
//                i_en    - increment enable
//                o_count - current count
//                o_next  - post-increment value for this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    output      logic [CNT_W-1:0] o_count,
    output      logic [CNT_W-1:0] o_next
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (i_en && (r_count != {CNT_W{1'b1}})) begin
            w_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
    assign o_next  = w_next;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_perf_monitor
//  Description : Performance monitor for the 5-stage pipelined CPU. Counts
//                cycles, data-hazard stalls, flushes and retired
//                instructions while running, halts the run after
//                CYCLE_LIMIT counted cycles, and exposes everything through
//                a registered read port.
//  Ports       : clk_i  - clock
//                rst_i  - synchronous reset, active-low
//                bus    - pipe_perf_monitor_if.slave (status in, read out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_monitor
    import cpu_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int unsigned CYCLE_LIMIT = 30
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    pipe_perf_monitor_if.slave     bus
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(CYCLE_LIMIT);

    logic [1:0]       r_state;
    logic             r_halt;
    logic [CNT_W-1:0] r_rdata;

    logic             w_count_en;
    logic             w_limit_hit;
    logic [PM_NUM_CNT-1:0] w_inc;
    logic [CNT_W-1:0] w_cnt  [PM_NUM_CNT];
    logic [CNT_W-1:0] w_next [PM_NUM_CNT];
    logic [CNT_W-1:0] w_rdata;

    // Counting only happens while registered state is RUN and the CPU still
    // requests running; in IDLE/HALTED the AND with 0 masks any X on inputs.
    assign w_count_en = (r_state == PM_RUN) && bus.start_i;

    // Stalls caused by control hazards (jump/branch in ID) are not data
    // hazard stalls and are excluded.
    assign w_inc[PM_CNT_CYCLE]  = w_count_en;
    assign w_inc[PM_CNT_STALL]  = w_count_en && bus.stall_i && !bus.is_jump_i && !bus.is_branch_i;
    assign w_inc[PM_CNT_FLUSH]  = w_count_en && bus.flush_i;
    assign w_inc[PM_CNT_RETIRE] = w_count_en && bus.retire_i;

    generate
        for (genvar gi = 0; gi < PM_NUM_CNT; gi++) begin : g_counters
            sat_counter #(
                .CNT_W   (CNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .i_clr   (bus.clear_i),
                .i_en    (w_inc[gi]),
                .o_count (w_cnt[gi]),
                .o_next  (w_next[gi])
            );
        end
    endgenerate

    // Compare against the post-increment value so exactly CYCLE_LIMIT
    // cycles are counted before halting.
    assign w_limit_hit = (CYCLE_LIMIT != 0) && w_count_en
                         && (w_next[PM_CNT_CYCLE] == c_limit);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= PM_IDLE;
            r_halt  <= 1'b0;
        end else if (bus.clear_i) begin
            r_state <= PM_IDLE;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                PM_IDLE: begin
                    if (bus.start_i) begin
                        r_state <= PM_RUN;
                    end
                end
                PM_RUN: begin
                    if (!bus.start_i) begin
                        r_state <= PM_IDLE;
                    end else if (w_limit_hit) begin
                        r_state <= PM_HALTED;
                        r_halt  <= 1'b1;
                    end
                end
                PM_HALTED: begin
                    r_state <= PM_HALTED;
                end
                default: begin
                    r_state <= PM_IDLE;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.sel_i)
            PM_SEL_CYCLE:  w_rdata = w_cnt[PM_CNT_CYCLE];
            PM_SEL_STALL:  w_rdata = w_cnt[PM_CNT_STALL];
            PM_SEL_FLUSH:  w_rdata = w_cnt[PM_CNT_FLUSH];
            PM_SEL_RETIRE: w_rdata = w_cnt[PM_CNT_RETIRE];
            PM_SEL_STATUS: w_rdata = CNT_W'(pm_status(r_halt, r_state));
            default:       w_rdata = '0;
        endcase
    end

    // Read port samples the current (pre-edge) values every cycle, so a
    // clear on edge k shows up as 0 from edge k+1.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign bus.rdata_o = r_rdata;
    assign bus.halt_o  = r_halt;
    assign bus.state_o = r_state;

endmodule : pipe_perf_monitor
`default_nettype wire

// File: tb/tb_pipe_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_perf_monitor
//  Description : Directed self-checking bench. dut_a uses default parameters
//                (32-bit, limit 30); dut_b uses CNT_W=4 with no limit for
//                the saturation and read-sweep checks. Both see the same
//                inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_perf_monitor;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start, stall, is_jump, is_branch, flush, retire, clear;
    logic [2:0] sel;

    int total = 0;
    int bad   = 0;

    pipe_perf_monitor_if #(.CNT_W(32)) ifa ();
    pipe_perf_monitor_if #(.CNT_W(4))  ifb ();

    assign ifa.start_i     = start;
    assign ifa.stall_i     = stall;
    assign ifa.is_jump_i   = is_jump;
    assign ifa.is_branch_i = is_branch;
    assign ifa.flush_i     = flush;
    assign ifa.retire_i    = retire;
    assign ifa.clear_i     = clear;
    assign ifa.sel_i       = sel;

    assign ifb.start_i     = start;
    assign ifb.stall_i     = stall;
    assign ifb.is_jump_i   = is_jump;
    assign ifb.is_branch_i = is_branch;
    assign ifb.flush_i     = flush;
    assign ifb.retire_i    = retire;
    assign ifb.clear_i     = clear;
    assign ifb.sel_i       = sel;

    pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) dut_a (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifa.slave)
    );

    pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_b (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifb.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Read one dut_a counter; only used while dut_a is not counting.
    task automatic read_a(input logic [2:0] s, input logic [31:0] exp, input string tag);
        sel = s;
        tick(1);
        check(tag, ifa.rdata_o, exp);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; start = 0; stall = 0; is_jump = 0; is_branch = 0;
        flush = 0; retire = 0; clear = 0; sel = 3'd0;

        // ---------------- reset ----------------
        tick(2);
        check("rst_state", 32'(ifa.state_o), 32'd0);
        check("rst_halt",  32'(ifa.halt_o),  32'd0);
        check("rst_rdata", ifa.rdata_o,      32'd0);

        // ---------------- reset then start, run to limit ----------------
        rst_i = 1'b1;
        start = 1'b1;
        tick(1);                                  // IDLE->RUN, not counted
        check("run_state", 32'(ifa.state_o), 32'd1);
        tick(29);
        check("pre_limit_halt",  32'(ifa.halt_o),  32'd0);
        check("pre_limit_state", 32'(ifa.state_o), 32'd1);
        tick(1);                                  // 30th counted edge
        check("limit_halt",  32'(ifa.halt_o),  32'd1);
        check("limit_state", 32'(ifa.state_o), 32'd2);
        tick(2);                                  // HALTED ignores start
        read_a(3'd0, 32'd30, "halt_cycle");
        read_a(3'd1, 32'd0,  "halt_stall");
        read_a(3'd2, 32'd0,  "halt_flush");
        read_a(3'd3, 32'd0,  "halt_retire");
        read_a(3'd4, 32'd6,  "halt_status");

        // ---------------- clear in HALTED ----------------
        start = 1'b0;
        clear_pulse();
        check("clr_halt",  32'(ifa.halt_o),  32'd0);
        check("clr_state", 32'(ifa.state_o), 32'd0);
        read_a(3'd0, 32'd0, "clr_cycle");

        // ---------------- stall filtering ----------------
        start = 1'b1;
        tick(1);
        stall = 1'b1;
        tick(5);
        is_branch = 1'b1;
        tick(3);
        is_branch = 1'b0;
        is_jump   = 1'b1;
        tick(2);
        is_jump = 1'b0;
        stall   = 1'b0;
        start   = 1'b0;
        tick(1);                                  // RUN->IDLE, not counted
        read_a(3'd1, 32'd5,  "filt_stall");
        read_a(3'd0, 32'd10, "filt_cycle");

        // ---------------- simultaneous events ----------------
        start = 1'b1;
        tick(1);
        stall = 1'b1; flush = 1'b1; retire = 1'b1;
        tick(1);
        stall = 1'b0; flush = 1'b0; retire = 1'b0;
        start = 1'b0;
        tick(1);
        read_a(3'd0, 32'd11, "sim_cycle");
        read_a(3'd1, 32'd6,  "sim_stall");
        read_a(3'd2, 32'd1,  "sim_flush");
        read_a(3'd3, 32'd1,  "sim_retire");

        // ---------------- pause / resume ----------------
        clear_pulse();
        start = 1'b1;
        tick(11);                                 // 1 start edge + 10 counted
        start = 1'b0;
        tick(1);
        check("pause_state0", 32'(ifa.state_o), 32'd0);
        tick(3);
        check("pause_state3", 32'(ifa.state_o), 32'd0);
        start = 1'b1;
        tick(6);                                  // 1 restart edge + 5 counted
        check("resume_state", 32'(ifa.state_o), 32'd1);
        start = 1'b0;
        tick(1);
        read_a(3'd0, 32'd15, "resume_cycle");

        // ---------------- clear mid-run ----------------
        clear_pulse();
        start  = 1'b1;
        retire = 1'b1;
        tick(13);                                 // counters reach 12
        retire = 1'b0;
        sel    = 3'd0;
        clear  = 1'b1;
        tick(1);                                  // rdata samples pre-clear 12
        check("mid_clr_pre_rdata", ifa.rdata_o, 32'd12);
        check("mid_clr_state", 32'(ifa.state_o), 32'd0);
        clear = 1'b0;
        start = 1'b0;
        tick(1);
        check("mid_clr_rdata", ifa.rdata_o, 32'd0);
        read_a(3'd3, 32'd0, "mid_clr_retire");

        // ---------------- saturation / read sweep on dut_b ----------------
        clear_pulse();
        start  = 1'b1;
        tick(1);
        retire = 1'b1;
        flush  = 1'b1;
        tick(3);
        flush  = 1'b0;
        tick(17);                                 // 20 counted total
        retire = 1'b0;
        check("sat_state", 32'(ifb.state_o), 32'd1);
        begin
            logic [3:0] exp_sweep [8];
            exp_sweep = '{4'd15, 4'd0, 4'd3, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0};
            for (int s = 0; s < 8; s++) begin
                sel = 3'(s);
                tick(1);
                check($sformatf("sweep_sel%0d", s), 32'(ifb.rdata_o), 32'(exp_sweep[s]));
            end
        end
        start = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_perf_monitor
`default_nettype wire
